// File: rtl/fetch_stage.sv
// fetch_stage: RV64 instruction-fetch stage; owns the PC and loads the IF/ID register
// from a combinational instruction memory, with stall, branch/trap redirect and fault hold.
module fetch_stage #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] pc_addr,
    input  logic [31:0]     imem_instr,
    input  logic            imem_exc_en,
    input  logic [3:0]      imem_exc_code,
    input  logic [XLEN-1:0] imem_exc_val,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            id_exc_en,
    output logic [3:0]      id_exc_code,
    output logic [XLEN-1:0] id_exc_val,
    output logic [XLEN-1:0] fetch_cnt
);
    localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, FAULT_HOLD = 2'd2;
    logic [1:0]      state_q;
    logic [XLEN-1:0] pc_q;
    logic            misal, fault;
    logic [3:0]      f_code;
    logic [XLEN-1:0] f_val;
    assign pc_addr = pc_q;
    // misalignment outranks a memory fault in both cause and value
    always_comb begin
        misal  = |pc_q[1:0];
        fault  = misal | imem_exc_en;
        f_code = misal ? 4'd0 : (imem_exc_en ? imem_exc_code : 4'd0);
        f_val  = misal ? pc_q : (imem_exc_en ? imem_exc_val : '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VEC;
            state_q     <= BOOT;
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_instr    <= NOP_INSTR;
            id_exc_en   <= 1'b0;
            id_exc_code <= 4'd0;
            id_exc_val  <= '0;
            fetch_cnt   <= '0;
        end else if (trap_en || br_taken) begin
            pc_q        <= trap_en ? trap_target : br_target;
            state_q     <= RUN;
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_exc_en   <= 1'b0;
            id_exc_code <= 4'd0;
            id_exc_val  <= '0;
        end else if (!stall) begin
            if (state_q == RUN) begin
                id_valid    <= 1'b1;
                id_pc       <= pc_q;
                id_instr    <= fault ? NOP_INSTR : imem_instr;
                id_exc_en   <= fault;
                id_exc_code <= f_code;
                id_exc_val  <= f_val;
                fetch_cnt   <= fetch_cnt + XLEN'(1);
                if (fault) state_q <= FAULT_HOLD;
                else pc_q <= pc_q + XLEN'(4);
            end else begin
                id_valid    <= 1'b0;
                id_instr    <= NOP_INSTR;
                id_exc_en   <= 1'b0;
                id_exc_code <= 4'd0;
                id_exc_val  <= '0;
                if (state_q == BOOT) state_q <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage; expected per-edge snapshots are queued
// by the stimulus and compared by an independent monitor just after each rising edge.
module tb_fetch_stage;
    typedef struct packed {
        logic [63:0] pc;
        logic        v;
        logic [63:0] ipc;
        logic [31:0] ins;
        logic        ee;
        logic [3:0]  ec;
        logic [63:0] ev;
        logic [63:0] cnt;
    } snap_t;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, br_taken = 1'b0, trap_en = 1'b0;
    logic [63:0] br_target = '0, trap_target = '0, pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en = 1'b0;
    logic [3:0]  imem_exc_code = 4'd0;
    logic [63:0] imem_exc_val = '0;
    logic        id_valid, id_exc_en;
    logic [63:0] id_pc, id_exc_val, fetch_cnt;
    logic [31:0] id_instr;
    logic [3:0]  id_exc_code;

    snap_t exp_q[$];
    int n_vec = 0, n_bad = 0;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_instr = mem(pc_addr);

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .trap_en(trap_en), .trap_target(trap_target), .pc_addr(pc_addr),
        .imem_instr(imem_instr), .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code),
        .imem_exc_val(imem_exc_val), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_exc_en(id_exc_en), .id_exc_code(id_exc_code), .id_exc_val(id_exc_val),
        .fetch_cnt(fetch_cnt)
    );

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            snap_t e, g;
            e = exp_q.pop_front();
            g = '{pc_addr, id_valid, id_pc, id_instr, id_exc_en, id_exc_code, id_exc_val, fetch_cnt};
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL vec%0d: got pc=%h v=%b ipc=%h ins=%h ee=%b ec=%h ev=%h cnt=%0d / want pc=%h v=%b ipc=%h ins=%h ee=%b ec=%h ev=%h cnt=%0d",
                    n_vec, g.pc, g.v, g.ipc, g.ins, g.ee, g.ec, g.ev, g.cnt,
                    e.pc, e.v, e.ipc, e.ins, e.ee, e.ec, e.ev, e.cnt);
            end
        end
    end

    task automatic chk(input logic [63:0] pc, input logic v, input logic [63:0] ipc,
                       input logic [31:0] ins, input logic ee, input logic [3:0] ec,
                       input logic [63:0] ev, input logic [63:0] cnt);
        exp_q.push_back('{pc, v, ipc, ins, ee, ec, ev, cnt});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        chk(64'h0, 0, 64'h0, NOP, 0, 0, 0, 0);
        rst = 1'b0;
        chk(64'h0, 0, 64'h0, NOP, 0, 0, 0, 0);
        chk(64'h4, 1, 64'h0, mem(64'h0), 0, 0, 0, 1);
        chk(64'h8, 1, 64'h4, mem(64'h4), 0, 0, 0, 2);
        chk(64'hC, 1, 64'h8, mem(64'h8), 0, 0, 0, 3);
        chk(64'h10, 1, 64'hC, mem(64'hC), 0, 0, 0, 4);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) chk(64'h10, 1, 64'hC, mem(64'hC), 0, 0, 0, 4);
        stall = 1'b0;
        chk(64'h14, 1, 64'h10, mem(64'h10), 0, 0, 0, 5);
        stall = 1'b1; br_taken = 1'b1; br_target = 64'h100;
        chk(64'h100, 0, 64'h10, NOP, 0, 0, 0, 5);
        stall = 1'b0; br_taken = 1'b0;
        chk(64'h104, 1, 64'h100, mem(64'h100), 0, 0, 0, 6);
        br_taken = 1'b1; br_target = 64'h4000;
        chk(64'h4000, 0, 64'h100, NOP, 0, 0, 0, 6);
        br_taken = 1'b0; imem_exc_en = 1'b1; imem_exc_code = 4'd1; imem_exc_val = 64'h4000;
        chk(64'h4000, 1, 64'h4000, NOP, 1, 4'd1, 64'h4000, 7);
        for (int i = 0; i < 5; i++) chk(64'h4000, 0, 64'h4000, NOP, 0, 0, 0, 7);
        imem_exc_en = 1'b0; trap_en = 1'b1; trap_target = 64'h80;
        chk(64'h80, 0, 64'h4000, NOP, 0, 0, 0, 7);
        trap_en = 1'b0;
        chk(64'h84, 1, 64'h80, mem(64'h80), 0, 0, 0, 8);
        br_taken = 1'b1; br_target = 64'h102;
        chk(64'h102, 0, 64'h80, NOP, 0, 0, 0, 8);
        br_taken = 1'b0; imem_exc_en = 1'b1; imem_exc_code = 4'd5; imem_exc_val = 64'hDEAD;
        chk(64'h102, 1, 64'h102, NOP, 1, 4'd0, 64'h102, 9);
        imem_exc_en = 1'b0;
        chk(64'h102, 0, 64'h102, NOP, 0, 0, 0, 9);
        stall = 1'b1; trap_en = 1'b1; trap_target = 64'h200; br_taken = 1'b1; br_target = 64'h300;
        chk(64'h200, 0, 64'h102, NOP, 0, 0, 0, 9);
        stall = 1'b0; trap_en = 1'b0; br_taken = 1'b0;
        chk(64'h204, 1, 64'h200, mem(64'h200), 0, 0, 0, 10);
        br_taken = 1'b1; br_target = 64'h3;
        chk(64'h3, 0, 64'h200, NOP, 0, 0, 0, 10);
        br_taken = 1'b0;
        chk(64'h3, 1, 64'h3, NOP, 1, 4'd0, 64'h3, 11);
        chk(64'h3, 0, 64'h3, NOP, 0, 0, 0, 11);
        rst = 1'b1;
        chk(64'h0, 0, 64'h0, NOP, 0, 0, 0, 0);
        rst = 1'b0;
        chk(64'h0, 0, 64'h0, NOP, 0, 0, 0, 0);
        chk(64'h4, 1, 64'h0, mem(64'h0), 0, 0, 0, 1);
        br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        chk(64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, NOP, 0, 0, 0, 1);
        br_taken = 1'b0;
        chk(64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, mem(64'hFFFF_FFFF_FFFF_FFFC), 0, 0, 0, 2);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV64 core.
- Owns the program counter and drives it to the combinational instruction memory, which returns the instruction and its fetch-exception fields in the same cycle.
- Captures the returned word, PC and exception fields into the IF/ID pipeline register.
- Handles stall, branch redirect, trap redirect and fetch-fault hold.

Parameters:
- XLEN, 64, PC and exception-value width.
- RESET_VEC, 64'h0000_0000_0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h00000013, instruction word placed in IF/ID on bubbles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  hold PC and IF/ID contents (decode hazard).
- br_taken  in  1  branch/jump redirect from execute.
- br_target  in  XLEN  branch/jump target.
- trap_en  in  1  trap/mret redirect from CSR unit.
- trap_target  in  XLEN  trap vector or mepc.
- pc_addr  out  XLEN  current fetch PC to instruction memory (= pc_q).
- imem_instr  in  32  instruction word from memory.
- imem_exc_en  in  1  memory fetch fault.
- imem_exc_code  in  4  memory fault cause.
- imem_exc_val  in  XLEN  memory fault value.
- id_valid  out  1  IF/ID holds a real instruction.
- id_pc  out  XLEN  PC of IF/ID instruction.
- id_instr  out  32  IF/ID instruction.
- id_exc_en  out  1  IF/ID carries a fetch exception.
- id_exc_code  out  4  exception cause.
- id_exc_val  out  XLEN  exception value (faulting PC).
- fetch_cnt  out  XLEN  count of instructions delivered with id_valid=1.

Behaviour:
- Reset (sync, rst=1 at rising edge):
  - pc_q=RESET_VEC, state=BOOT, id_valid=0, id_pc=0, id_instr=NOP_INSTR, id_exc_en=0, id_exc_code=0, id_exc_val=0, fetch_cnt=0.
  - Reset mid-operation discards everything, including a pending FAULT_HOLD.
- States: BOOT, RUN, FAULT_HOLD.
- BOOT: one cycle; IF/ID stays bubble, pc_q unchanged; next state RUN. Memory outputs are ignored in this cycle.
- Per-edge priority, highest first: rst > trap_en > br_taken > stall > state action.
- trap_en=1: pc_q<=trap_target; IF/ID<=bubble; state<=RUN. Applies from any state, and overrides br_taken and stall.
- br_taken=1 (no trap): pc_q<=br_target; IF/ID<=bubble; state<=RUN. Also applies in FAULT_HOLD.
- stall=1 (no redirect): pc_q, IF/ID, state and fetch_cnt all hold.
- RUN, no stall, no redirect:
  - Fault detect: fault = imem_exc_en OR (pc_q[1:0]!=0).
  - No fault: IF/ID <= {valid=1, pc_q, imem_instr, exc fields 0}; pc_q <= pc_q+4, wrapping mod 2^XLEN; fetch_cnt+1.
  - Fault: IF/ID <= {valid=1, pc_q, NOP_INSTR, exc_en=1}; pc_q holds; state<=FAULT_HOLD; fetch_cnt+1.
  - Misaligned cause: exc_code=0, exc_val=pc_q. Misalignment takes precedence over imem_exc_en.
  - Memory fault cause: exc_code=imem_exc_code, exc_val=imem_exc_val.
- FAULT_HOLD: IF/ID <= bubble each unstalled cycle; pc_q holds; no further exception is issued. Exits only via redirect or reset.
- Bubble definition: valid=0, instr=NOP_INSTR, exc_en=0, code=0, val=0; id_pc keeps its last value.
- Latency: the instruction at PC P appears on id_* one edge after pc_addr=P. A redirect target is presented on pc_addr the cycle after the redirect edge, and is valid on id_* the edge after that.
- Arithmetic:
  - fetch_cnt is XLEN bits and wraps.
  - fetch_cnt counts only edges that load id_valid=1.
- Outputs are registered. pc_addr is driven directly from pc_q.

Test Plan:
- Reset, RESET_VEC=0 -> pc_addr=0x0, id_valid=0 for two edges (reset + BOOT); then instr at 0x0 on id_*, with pc_addr=0x4 on the same edge.
- Sequential fetch of 4 words from 0x0, then stall=1 for 3 cycles -> pc_addr sticks at 0x10, id_pc stays 0xC, fetch_cnt stays 4. Release -> instr at 0x10 delivered.
- br_taken with br_target=0x100 while stall=1 -> next edge id_valid=0 and pc_addr=0x100; the following edge gives id_pc=0x100.
- imem_exc_en=1 with code 1 at pc 0x4000 -> id_exc_en=1, code 1, id_exc_val=0x4000, id_instr=0x00000013. Following 5 cycles: id_valid=0 and pc_addr stays 0x4000. Then trap_en with target 0x80 -> fetch resumes at 0x80.
- br_target=0x102 -> next fetch gives id_exc_en=1, code 0, val=0x102, and the block enters FAULT_HOLD.
- trap_en=1 and br_taken=1 in the same cycle (trap 0x200, branch 0x300) -> pc_addr=0x200. Also: rst asserted while in FAULT_HOLD -> all outputs return to reset values and pc_addr=RESET_VEC.
